// File: rtl/tseq_ctrl_if.sv
// Configuration, run-control and status bundle for the T-flip-flop sequencer.
// Master drives table writes and run control; slave reports sequenced state.
interface tseq_ctrl_if #(
  parameter int unsigned W  = 2,
  parameter int unsigned LW = 8
);
  logic          cfg_we;
  logic [W-1:0]  cfg_addr;
  logic [W-1:0]  cfg_data;
  logic          cfg_err;
  logic          start;
  logic [LW-1:0] run_len;
  logic          stop;
  logic          step;
  logic [W-1:0]  q;
  logic [W-1:0]  t;
  logic          busy;
  logic          done;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, run_len, stop, step,
    input  cfg_err, q, t, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, run_len, stop, step,
    output cfg_err, q, t, busy, done
  );
endinterface

// File: rtl/tseq_ctrl.sv
// Table-driven sequencer for a W-bit T-flip-flop register: each advance moves
// q to table[q], and t exposes the toggle vector that advance applies.
module tseq_ctrl #(
  parameter int unsigned W  = 2,
  parameter int unsigned LW = 8
) (
  input logic         clk,
  input logic         nrst,
  tseq_ctrl_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << W;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state, state_n;
  logic [W-1:0]  tbl [DEPTH];
  logic [W-1:0]  q, q_n, nxt;
  logic [LW-1:0] rem, rem_n;
  logic          done, done_n;
  logic          cfg_err, cfg_err_n;
  logic          advance;
  logic          tbl_we;

  assign nxt = tbl[q];

  always_comb begin
    state_n   = state;
    q_n       = q;
    rem_n     = rem;
    done_n    = 1'b0;
    advance   = 1'b0;
    tbl_we    = bus.cfg_we && (state == IDLE);
    cfg_err_n = bus.cfg_we && (state != IDLE);

    // stop outranks start, which outranks step
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.run_len != '0) begin
            rem_n   = bus.run_len;
            state_n = RUN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.stop) state_n = PAUSE;
        else          advance = (rem != '0);
      end
      PAUSE: begin
        if (bus.stop)       state_n = IDLE;
        else if (bus.start) state_n = RUN;
        else if (bus.step)  advance = (rem != '0);
      end
      default: state_n = IDLE;
    endcase

    if (advance) begin
      q_n   = nxt;
      rem_n = rem - LW'(1);
      if (rem == LW'(1)) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      q       <= '0;
      rem     <= '0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= W'(i + 1);
    end else begin
      state   <= state_n;
      q       <= q_n;
      rem     <= rem_n;
      done    <= done_n;
      cfg_err <= cfg_err_n;
      if (tbl_we) tbl[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  assign bus.q       = q;
  assign bus.t       = advance ? (q ^ nxt) : '0;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done;
  assign bus.cfg_err = cfg_err;
endmodule

// File: tb/tb_tseq_ctrl.sv
// Directed vector bench for tseq_ctrl: per-cycle stimulus/expectation table
// plus a hand-written asynchronous mid-run reset sequence.
module tb_tseq_ctrl;
  localparam int unsigned W  = 2;
  localparam int unsigned LW = 8;

  typedef struct {
    bit          rst;
    bit          we;
    logic [1:0]  addr;
    logic [1:0]  data;
    bit          st;
    logic [7:0]  len;
    bit          sp;
    bit          stp;
    logic [1:0]  eq;
    logic [1:0]  et;
    bit          eb;
    bit          ed;
    bit          ee;
  } vec_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  tseq_ctrl_if #(.W(W), .LW(LW)) bus ();

  tseq_ctrl #(.W(W), .LW(LW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit we, input logic [1:0] addr,
                     input logic [1:0] data, input bit st, input logic [7:0] len,
                     input bit sp, input bit stp, input logic [1:0] eq,
                     input logic [1:0] et, input bit eb, input bit ed, input bit ee);
    vec_t v;
    v.rst = rst; v.we = we; v.addr = addr; v.data = data; v.st = st;
    v.len = len; v.sp = sp; v.stp = stp; v.eq = eq; v.et = et;
    v.eb = eb; v.ed = ed; v.ee = ee;
    vecs.push_back(v);
  endtask

  // cycle with no inputs asserted
  task automatic idle(input logic [1:0] eq, input logic [1:0] et,
                      input bit eb, input bit ed, input bit ee);
    add(0, 0, 0, 0, 0, 0, 0, 0, eq, et, eb, ed, ee);
  endtask

  task automatic drive_zero();
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.start = 0; bus.run_len = '0; bus.stop = 0; bus.step = 0;
  endtask

  task automatic check_outs(input string tag, input int idx, input logic [1:0] eq,
                            input logic [1:0] et, input bit eb, input bit ed, input bit ee);
    check({tag, ".q"},       idx, 8'(bus.q),       8'(eq));
    check({tag, ".t"},       idx, 8'(bus.t),       8'(et));
    check({tag, ".busy"},    idx, 8'(bus.busy),    8'(eb));
    check({tag, ".done"},    idx, 8'(bus.done),    8'(ed));
    check({tag, ".cfg_err"}, idx, 8'(bus.cfg_err), 8'(ee));
  endtask

  initial begin
    drive_zero();

    // default table, run of 5 from q=0
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 2'b01, 1, 0, 0);
    idle(1, 2'b11, 1, 0, 0);
    idle(2, 2'b01, 1, 0, 0);
    idle(3, 2'b11, 1, 0, 0);
    idle(0, 2'b01, 1, 0, 0);
    idle(1, 0, 0, 1, 0);
    idle(1, 0, 0, 0, 0);

    // programmed table 0->1->3->2->0, run of 4
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 2'b01, 1, 0, 0);
    idle(1, 2'b10, 1, 0, 0);
    idle(3, 2'b01, 1, 0, 0);
    idle(2, 2'b10, 1, 0, 0);
    idle(0, 0, 0, 1, 0);
    idle(0, 0, 0, 0, 0);

    // run of 6 split across RUN, two steps, and resume
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 2'b01, 1, 0, 0);
    idle(1, 2'b11, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 0, 0);
    idle(2, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 2, 2'b01, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 3, 2'b11, 1, 0, 0);
    add(0, 0, 0, 0, 1, 9, 0, 1, 0, 0, 1, 0, 0);
    idle(0, 2'b01, 1, 0, 0);
    idle(1, 2'b11, 1, 0, 0);
    idle(2, 0, 0, 1, 0);

    // table write while busy is rejected with a one-cycle error
    add(0, 0, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0, 0);
    add(0, 1, 0, 3, 0, 0, 0, 0, 2, 2'b01, 1, 0, 0);
    idle(3, 2'b11, 1, 0, 1);
    idle(0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 2'b01, 1, 0, 0);
    idle(1, 0, 0, 1, 0);

    // zero-length start, ignored stop/step in IDLE, abort from PAUSE
    add(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);
    idle(1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 3, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0);
    add(0, 1, 2, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 1);
    idle(1, 0, 0, 0, 0);
    idle(1, 0, 0, 0, 0);

    // write and start in the same cycle: first advance sees new entry
    add(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    idle(1, 2'b01, 1, 0, 0);
    idle(0, 0, 0, 1, 0);
    idle(0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      nrst         = vecs[i].rst ? 1'b0 : 1'b1;
      bus.cfg_we   = vecs[i].we;
      bus.cfg_addr = vecs[i].addr;
      bus.cfg_data = vecs[i].data;
      bus.start    = vecs[i].st;
      bus.run_len  = vecs[i].len;
      bus.stop     = vecs[i].sp;
      bus.step     = vecs[i].stp;
      #1;
      check_outs("vec", i, vecs[i].eq, vecs[i].et, vecs[i].eb, vecs[i].ed, vecs[i].ee);
    end

    // asynchronous reset mid-run restores the default table
    @(negedge clk);
    drive_zero();
    nrst = 1'b1;
    bus.cfg_we = 1; bus.cfg_addr = 0; bus.cfg_data = 2;
    @(negedge clk);
    drive_zero();
    bus.start = 1; bus.run_len = 10;
    @(negedge clk);
    drive_zero();
    #1;
    check_outs("rst_run", 0, 0, 2'b10, 1, 0, 0);
    @(negedge clk);
    #1;
    check_outs("rst_run", 1, 2, 2'b01, 1, 0, 0);
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check_outs("rst_mid", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    nrst = 1'b1;
    bus.start = 1; bus.run_len = 1;
    #1;
    check_outs("rst_after", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive_zero();
    #1;
    check_outs("rst_after", 1, 0, 2'b01, 1, 0, 0);
    @(negedge clk);
    #1;
    check_outs("rst_after", 2, 1, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
